// File: rtl/plc_io_ctrl.sv
// PLC I/O controller: debounced digital inputs, register-driven digital outputs,
// analog sample capture with threshold alarms, sticky status flags and a level IRQ.
module plc_io_ctrl #(
  parameter int DCH = 4,
  parameter int ACH = 1,
  parameter int AW  = 16,
  parameter int DEB = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [3:0]          addr_in,
  input  logic [15:0]         wdata_in,
  input  logic                we_in,
  input  logic                re_in,
  output logic [15:0]         rdata_out,
  output logic                rvalid_out,
  input  logic [DCH-1:0]      din_in,
  output logic [DCH-1:0]      dout_out,
  output logic [DCH-1:0]      doe_out,
  input  logic [ACH*AW-1:0]   ain_in,
  output logic                irq_out
);

  localparam int         NF     = DCH + ACH;
  localparam logic [7:0] DEB_TC = 8'(DEB - 1);

  logic [DCH-1:0] sync1;
  logic [DCH-1:0] sync2;
  logic [DCH-1:0] din_db;
  logic [DCH-1:0] edge_set;
  logic [7:0]     db_cnt [DCH];

  logic [DCH-1:0] dout_r;
  logic [DCH-1:0] dir_r;
  logic [NF-1:0]  stat_r;
  logic [NF-1:0]  ien_r;
  logic [NF-1:0]  stat_clr;
  logic [NF-1:0]  stat_set;

  logic [AW-1:0]  sample_r [ACH];
  logic [AW-1:0]  thr_r    [ACH];
  logic [ACH-1:0] alarm;

  logic [15:0]    rd_mux;
  logic           unused_wdata;

  assign unused_wdata = ^wdata_in;

  // Two-flop synchronizer on every raw pin before any other use
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din_in;
      sync2 <= sync1;
    end
  end

  // A channel flips on the DEB-th consecutive disagreeing cycle
  always_comb begin
    edge_set = '0;
    for (int i = 0; i < DCH; i++) begin
      edge_set[i] = (sync2[i] != din_db[i]) && (db_cnt[i] == DEB_TC);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_db <= '0;
      for (int i = 0; i < DCH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DCH; i++) begin
        if (sync2[i] == din_db[i]) begin
          db_cnt[i] <= '0;
        end else if (edge_set[i]) begin
          din_db[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < ACH; k++) begin
        sample_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ACH; k++) begin
        sample_r[k] <= ain_in[k*AW +: AW];
      end
    end
  end

  always_comb begin
    alarm = '0;
    for (int k = 0; k < ACH; k++) begin
      alarm[k] = (sample_r[k] >= thr_r[k]);
    end
  end

  // Writable configuration registers; bits above each register's width are dropped
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dout_r <= '0;
      dir_r  <= '0;
      ien_r  <= '0;
      for (int k = 0; k < ACH; k++) begin
        thr_r[k] <= '1;
      end
    end else if (we_in) begin
      case (addr_in)
        4'd1:    dout_r <= wdata_in[DCH-1:0];
        4'd2:    dir_r  <= wdata_in[DCH-1:0];
        4'd4:    ien_r  <= wdata_in[NF-1:0];
        default: ;
      endcase
      for (int k = 0; k < ACH; k++) begin
        if (addr_in == 4'(9 + k)) begin
          thr_r[k] <= wdata_in[AW-1:0];
        end
      end
    end
  end

  // Sticky flags; a set in the same cycle as a write-1-to-clear takes priority
  assign stat_clr = (we_in && (addr_in == 4'd3)) ? wdata_in[NF-1:0] : '0;
  assign stat_set = {alarm, edge_set};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_r  <= '0;
      irq_out <= 1'b0;
    end else begin
      stat_r  <= (stat_r & ~stat_clr) | stat_set;
      irq_out <= |(stat_r & ien_r);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr_in)
      4'd0: rd_mux[DCH-1:0] = din_db;
      4'd1: rd_mux[DCH-1:0] = dout_r;
      4'd2: rd_mux[DCH-1:0] = dir_r;
      4'd3: rd_mux[NF-1:0]  = stat_r;
      4'd4: rd_mux[NF-1:0]  = ien_r;
      default: begin
        for (int k = 0; k < ACH; k++) begin
          if (addr_in == 4'(5 + k)) rd_mux[AW-1:0] = sample_r[k];
          if (addr_in == 4'(9 + k)) rd_mux[AW-1:0] = thr_r[k];
        end
      end
    endcase
  end

  // Read data is captured from pre-write register values, so read-during-write sees old data
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdata_out  <= '0;
      rvalid_out <= 1'b0;
    end else if (re_in) begin
      rdata_out  <= rd_mux;
      rvalid_out <= 1'b1;
    end else begin
      rdata_out  <= '0;
      rvalid_out <= 1'b0;
    end
  end

  assign dout_out = dout_r;
  assign doe_out  = dir_r;

endmodule
